// File: rtl/bcd_digit_sequencer.sv
// bcd_digit_sequencer
//   Time-multiplexes one shared combinational 4-bit BCD code converter over
//   an NDIG-digit packed BCD word. A word is accepted on in_valid/in_ready.
//   Digits are driven one per cycle on p/q/r/s, starting with digit0 = [3:0].
//   Each result {a,b,c,d} is captured in the cycle its digit is driven.
//   The assembled word is returned on out_valid/out_ready.
//
//   Optional feature: define BCD_SEQ_ERR_EN to flag any digit > 9 on out_err.
//   The flag is sticky per word and cleared at accept. When the macro is
//   undefined, out_err is tied low.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_data             packed BCD word, 4*NDIG bits
//   p,q,r,s             digit to converter (p = MSB)
//   a,b,c,d             converter result (a = MSB)
//   out_valid/out_ready output handshake
//   out_data            converted word, slot i = {a,b,c,d} of digit i
//   out_err             a digit > 9 was seen in this word
module bcd_digit_sequencer #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_data,
  output logic              p,
  output logic              q,
  output logic              r,
  output logic              s,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic              out_err
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   idx;
  logic [4*NDIG-1:0] word;
  logic [3:0]        cur_digit;
  logic [3:0]        conv;

  assign cur_digit = word[4*idx +: 4];
  assign conv      = {a, b, c, d};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    {p, q, r, s} = 4'b0000;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        {p, q, r, s} = cur_digit;
        if (idx == LAST_IDX) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      word     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word <= in_data;
            idx  <= '0;
          end
        end
        RUN: begin
          out_data[4*idx +: 4] <= conv;
          // Parking idx at 0 on the final digit keeps it within 0..NDIG-1.
          if (idx == LAST_IDX) idx <= '0;
          else                 idx <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_SEQ_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_err <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      out_err <= 1'b0;
    end else if (state == RUN && cur_digit > 4'd9) begin
      out_err <= 1'b1;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
module tb_bcd_digit_sequencer;

  localparam int NDIG = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] in_data;
  logic              p, q, r, s;
  logic              a, b, c, d;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_data;
  logic              out_err;

  int unsigned passed = 0;
  int unsigned fails  = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  // Excess-3 converter model.
  assign {a, b, c, d} = {p, q, r, s} + 4'd3;

  bcd_digit_sequencer #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .p        (p),
    .q        (q),
    .r        (r),
    .s        (s),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  // Reference model: each nibble converted independently, error if any digit is non-BCD.
  function automatic logic [4*NDIG-1:0] model_data(input logic [4*NDIG-1:0] w);
    logic [4*NDIG-1:0] res;
    res = '0;
    for (int i = 0; i < NDIG; i++) res[4*i +: 4] = 4'((w >> (4*i)) % 16 + 3);
    return res;
  endfunction

  function automatic logic model_err(input logic [4*NDIG-1:0] w);
    logic e;
    e = 1'b0;
`ifdef BCD_SEQ_ERR_EN
    for (int i = 0; i < NDIG; i++) if ((w >> (4*i)) % 16 > 9) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [3:0] model_digit(input logic [4*NDIG-1:0] w, input int i);
    return 4'((w >> (4*i)) % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full word transaction; hold_cycles of back-pressure with in_valid kept high.
  task automatic run_word(input logic [4*NDIG-1:0] w, input int hold_cycles);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    step();
    if (hold_cycles == 0) in_valid = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      chk("run_digit", 32'({p, q, r, s}), 32'(model_digit(w, i)));
      chk("run_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'(model_data(w)));
    chk("hold_err", 32'(out_err), 32'(model_err(w)));
    chk("hold_pqrs", 32'({p, q, r, s}), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      step();
      chk("bp_data", 32'(out_data), 32'(model_data(w)));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [4*NDIG-1:0] exp_q[$];
  logic              err_q[$];

  initial begin
    int accepts;
    int last_acc;
    int cyc;
    logic acc;
    logic rel;

    // T1 reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_pqrs", 32'({p, q, r, s}), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // T2 basic, T3 back-pressure
    run_word(16'h1234, 0);
    chk("t2_data", 32'(model_data(16'h1234)), 32'h4567);
    run_word(16'h1234, 10);

    // T4 error words, then random words
    run_word(16'h12A4, 0);
    run_word(16'h0009, 0);
    for (int k = 0; k < 6; k++) run_word(16'($urandom), k % 3);

    // T5 reset on the 2nd RUN edge
    in_data = 16'h5678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_pqrs", 32'({p, q, r, s}), 32'd0);
    chk("t5_out_data", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_no_result", 32'(out_valid), 32'd0);
    end

    // T6 streaming
    in_valid = 1'b1; out_ready = 1'b1;
    in_data  = 16'($urandom);
    accepts = 0; last_acc = -1; cyc = 0;
    while ((accepts < 5 || exp_q.size() > 0) && cyc < 100) begin
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      if (rel) begin
        if (exp_q.size() > 0) begin
          chk("t6_data", 32'(out_data), 32'(exp_q.pop_front()));
          chk("t6_err", 32'(out_err), 32'(err_q.pop_front()));
        end else begin
          chk("t6_unexpected_valid", 32'(out_valid), 32'd0);
        end
      end
      if (acc) begin
        exp_q.push_back(model_data(in_data));
        err_q.push_back(model_err(in_data));
        if (last_acc >= 0) chk("t6_period", 32'(cyc - last_acc), 32'(NDIG + 2));
        last_acc = cyc;
        accepts++;
      end
      step();
      cyc++;
      if (acc) begin
        if (accepts < 5) in_data = 16'($urandom);
        else             in_valid = 1'b0;
      end
    end
    chk("t6_accepts", 32'(accepts), 32'd5);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
